// File: rtl/cmd_decoder.sv
// cmd_decoder: parses 4-byte host frames (SYNC, CMD, DATA, CSUM) from the UART
// receiver, applies trace width/enable config and queues a one-byte reply
// toward the UART transmitter through a single-entry reply slot.
module cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 480000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       recv_error,
  input  logic       sync,
  input  logic       overflow,
  input  logic       tx_free,
  output logic       resp_valid,
  output logic [7:0] resp_byte,
  output logic [2:0] width,
  output logic       trace_en,
  output logic [7:0] err_count
);

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    ACK      = 8'h06;
  localparam logic [7:0]    NAK      = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_GETCMD, S_GETDATA, S_GETCSUM, S_EXEC
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    csum_q, csum_d;
  logic [2:0]    width_q, width_d;
  logic          trace_en_q, trace_en_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          slot_full_q, slot_full_d;
  logic [7:0]    slot_byte_q, slot_byte_d;
  logic          resp_valid_q, resp_valid_d;
  logic [7:0]    resp_byte_q, resp_byte_d;

  logic          byte_ok;
  logic          drain;
  logic          inc_err;
  logic          rep_load;
  logic [7:0]    rep_byte;

  // Next-state: frame parser, timeout, execution and reply slot handling
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    csum_d       = csum_q;
    width_d      = width_q;
    trace_en_d   = trace_en_q;
    err_cnt_d    = err_cnt_q;
    slot_full_d  = slot_full_q;
    slot_byte_d  = slot_byte_q;
    resp_valid_d = 1'b0;
    resp_byte_d  = resp_byte_q;
    inc_err      = 1'b0;
    rep_load     = 1'b0;
    rep_byte     = NAK;

    // A framing error in the same cycle as a byte poisons that byte
    byte_ok = received & ~recv_error;

    // Hand the pending reply to the transmitter as soon as it is idle
    drain = slot_full_q & tx_free;
    if (drain) begin
      resp_valid_d = 1'b1;
      resp_byte_d  = slot_byte_q;
      slot_full_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (byte_ok && rx_byte == SYNC_BYTE) state_d = S_GETCMD;
      end

      S_GETCMD, S_GETDATA, S_GETCSUM: begin
        if (recv_error) begin
          state_d = S_IDLE;
          tmo_d   = '0;
          inc_err = 1'b1;
        end else if (received) begin
          tmo_d = '0;
          case (state_q)
            S_GETCMD:  begin cmd_d  = rx_byte; state_d = S_GETDATA; end
            S_GETDATA: begin data_d = rx_byte; state_d = S_GETCSUM; end
            default:   begin csum_d = rx_byte; state_d = S_EXEC;    end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          // Host stalled mid-frame: abort, next byte must be a fresh SYNC
          state_d = S_IDLE;
          tmo_d   = '0;
          inc_err = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_EXEC: begin
        state_d  = S_IDLE;
        rep_load = 1'b1;
        if (csum_q != (cmd_q ^ data_q)) begin
          inc_err = 1'b1;
        end else begin
          case (cmd_q)
            8'h01: begin
              if (data_q == 8'd1 || data_q == 8'd2 || data_q == 8'd4) begin
                width_d  = data_q[2:0];
                rep_byte = ACK;
              end else begin
                inc_err = 1'b1;
              end
            end
            8'h02: begin
              trace_en_d = data_q[0];
              rep_byte   = ACK;
            end
            8'h03: rep_byte = {2'b00, overflow, sync, trace_en_q, width_q};
            default: inc_err = 1'b1;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Older reply wins; a slot that empties this very cycle can take the new one
    if (rep_load) begin
      if (slot_full_q && !drain) begin
        inc_err = 1'b1;
      end else begin
        slot_full_d = 1'b1;
        slot_byte_d = rep_byte;
      end
    end

    // All error sources in one cycle collapse to a single saturating bump
    if (inc_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      csum_q       <= '0;
      width_q      <= 3'h4;
      trace_en_q   <= 1'b1;
      err_cnt_q    <= '0;
      slot_full_q  <= 1'b0;
      slot_byte_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_byte_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      csum_q       <= csum_d;
      width_q      <= width_d;
      trace_en_q   <= trace_en_d;
      err_cnt_q    <= err_cnt_d;
      slot_full_q  <= slot_full_d;
      slot_byte_q  <= slot_byte_d;
      resp_valid_q <= resp_valid_d;
      resp_byte_q  <= resp_byte_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_byte  = resp_byte_q;
  assign width      = width_q;
  assign trace_en   = trace_en_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: scoreboard bench for cmd_decoder. Expected replies are queued
// when a frame is sent and popped by a monitor whenever resp_valid fires.
module tb_cmd_decoder;

  localparam int unsigned TMO = 64;
  localparam int          GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;
  logic       sync;
  logic       overflow;
  logic       tx_free;
  logic       resp_valid;
  logic [7:0] resp_byte;
  logic [2:0] width;
  logic       trace_en;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_err;

  cmd_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
    .recv_error(recv_error), .sync(sync), .overflow(overflow), .tx_free(tx_free),
    .resp_valid(resp_valid), .resp_byte(resp_byte), .width(width),
    .trace_en(trace_en), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every reply strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) chk("resp_unexpected", {24'h0, resp_byte}, 32'hFFFF_FFFF);
      else chk("resp_byte", {24'h0, resp_byte}, {24'h0, exp_q.pop_front()});
    end
  end

  function automatic logic [7:0] bump(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; received = 1'b0; recv_error = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_err = 8'h00;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); received = 1'b1; rx_byte = b;
    @(negedge clk); received = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] s);
    send_byte(8'hA5); send_byte(c); send_byte(d); send_byte(s);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_err(input logic with_byte);
    @(negedge clk); recv_error = 1'b1; received = with_byte; rx_byte = 8'h02;
    @(negedge clk); recv_error = 1'b0; received = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  initial begin
    sync = 1'b0; overflow = 1'b0; tx_free = 1'b1;
    do_reset();
    chk("rst_width", width, 3'h4);
    chk("rst_en", trace_en, 1'b1);
    chk("rst_err", err_count, 8'h00);
    chk("rst_rv", resp_valid, 1'b0);
    chk("rst_rb", resp_byte, 8'h00);

    // good set-width
    exp_q.push_back(8'h06); send_frame(8'h01, 8'h02, 8'h03);
    chk("w2_width", width, 3'h2);
    chk("w2_err", err_count, exp_err);

    // illegal width value, good checksum
    do_reset();
    exp_q.push_back(8'h15); send_frame(8'h01, 8'h03, 8'h02); exp_err = bump(exp_err);
    chk("w3_width", width, 3'h4);
    chk("w3_err", err_count, exp_err);

    // bad checksum, then enable off
    do_reset();
    exp_q.push_back(8'h15); send_frame(8'h01, 8'h02, 8'h00); exp_err = bump(exp_err);
    chk("bcs_width", width, 3'h4);
    chk("bcs_err", err_count, exp_err);
    exp_q.push_back(8'h06); send_frame(8'h02, 8'h00, 8'h02);
    chk("en0", trace_en, 1'b0);
    chk("en0_err", err_count, exp_err);

    // unknown command
    exp_q.push_back(8'h15); send_frame(8'h07, 8'h00, 8'h07); exp_err = bump(exp_err);
    chk("unk_err", err_count, exp_err);

    // timeout mid-frame, then status
    do_reset();
    send_byte(8'hA5); send_byte(8'h01);
    repeat (TMO + 4) @(negedge clk);
    exp_err = bump(exp_err);
    chk("tmo_err", err_count, exp_err);
    sync = 1'b1; overflow = 1'b0;
    exp_q.push_back(8'h1C); send_frame(8'h03, 8'h00, 8'h03);
    chk("stat_err", err_count, exp_err);
    overflow = 1'b1;
    exp_q.push_back(8'h3C); send_frame(8'h03, 8'h00, 8'h03);

    // long but sub-threshold inter-byte gap still completes
    send_byte(8'hA5); repeat (TMO - 10) @(negedge clk);
    send_byte(8'h01); repeat (TMO - 10) @(negedge clk);
    exp_q.push_back(8'h06);
    send_byte(8'h01); send_byte(8'h00); repeat (4) @(negedge clk);
    chk("slow_width", width, 3'h1);
    chk("slow_err", err_count, exp_err);

    // non-sync bytes in IDLE are silently dropped
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h01);
    chk("junk_err", err_count, exp_err);

    // recv_error during GETDATA; leftover bytes must not form a frame
    send_byte(8'hA5); send_byte(8'h01); pulse_err(1'b0);
    exp_err = bump(exp_err);
    chk("rxe_err", err_count, exp_err);
    send_byte(8'h04); send_byte(8'h05); repeat (4) @(negedge clk);
    chk("rxe_width", width, 3'h1);
    chk("rxe_err2", err_count, exp_err);

    // error and byte in the same cycle: error wins
    send_byte(8'hA5); pulse_err(1'b1);
    exp_err = bump(exp_err);
    send_byte(8'h02); send_byte(8'h02); repeat (4) @(negedge clk);
    chk("both_err", err_count, exp_err);
    chk("both_en", trace_en, 1'b1);

    // transmitter busy: second reply dropped, config still applied
    tx_free = 1'b0;
    exp_q.push_back(8'h06); send_frame(8'h01, 8'h04, 8'h05);
    send_frame(8'h02, 8'h00, 8'h02); exp_err = bump(exp_err);
    chk("busy_width", width, 3'h4);
    chk("busy_en", trace_en, 1'b0);
    chk("busy_err", err_count, exp_err);
    chk("busy_pending", exp_q.size(), 1);
    tx_free = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_drained", exp_q.size(), 0);

    // reset with reply pending discards it
    tx_free = 1'b0;
    send_frame(8'h01, 8'h02, 8'h03);
    do_reset();
    tx_free = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstp_width", width, 3'h4);

    // saturation over 300 bad frames
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(8'h15);
      send_frame(8'h01, 8'h02, 8'hFF);
      exp_err = bump(exp_err);
    end
    chk("sat_err", err_count, 8'hFF);
    chk("sat_width", width, 3'h4);

    repeat (6) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
